alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, multi-stage successor to the 8-bit single-stage ALU.
//  Operand width, pipeline depth and op set (8 ops, 3-bit ctl) are generalised; a zero flag is added.
//  Sits between an upstream push/stop producer and a downstream consumer; never drops or reorders data.
// PARAMETERS
//  W       8  operand/result width; legal range 4..64.
//  STAGES  2  pipeline depth (register stages); legal range 1..4.
// PORTS
//  clk      in   1        clock; all state updates on posedge clk.
//  rst      in   1        reset, synchronous, active-high.
//  pushin   in   1        upstream offers a transaction this cycle.
//  stopout  out  1        upstream must hold its transaction (not accepted).
//  ctl      in   3        operation select (see BEHAVIOUR).
//  a        in   W        operand A.
//  b        in   W        operand B / shift amount.
//  ci       in   1        carry in (add/sub only).
//  pushout  out  1        result valid at output stage.
//  stopin   in   1        downstream stall; output stage holds while pushout&&stopin.
//  z        out  W        result.
//  cout     out  1        carry/borrow-bar/shifted-out bit.
//  zf       out  1        1 when z==0 (valid with pushout).
// BEHAVIOUR
//  Reset: rst high at a posedge clears every stage valid bit and data register; stopout=0 after reset
//   (stopin permitting); pushout=0, z=0, cout=0, zf=1. A transaction held mid-stall is discarded by reset.
//  Datapath: ctl/a/b/ci are evaluated combinationally at the input; stage 1 captures {z,cout,zf};
//   stages 2..STAGES only carry. Stage STAGES drives the outputs directly from registers.
//  Ops (W-bit, results truncated to W, carry in bit W):
//   000 z=a, cout=0 | 001 {cout,z}=a+b+ci | 010 {cout,z}=a+~b+ci (ci=1 -> plain a-b; cout=1 means no borrow)
//   011 a^b | 100 a&b | 101 a|b  (cout=0 for 011..101)
//   110 z=a<<s, 111 z=a>>s (logical); s=b[$clog2(W)-1:0]; cout=last bit shifted out; s=0 -> cout=0;
//   s>=W (non-power-of-2 W) -> z=0, cout=0.
//  Handshake: stage k holds iff valid_k && hold_(k+1); hold_(STAGES+1)=stopin.
//   Holding stage keeps its data; non-holding stage loads from previous (bubbles collapse).
//   stopout = valid_1 && hold_2 (combinational path stopin->stopout is permitted).
//   Input accepted when pushin && !stopout; when stopout=1 a,b,ctl,ci,pushin are ignored.
//  Latency: accepted at edge t -> pushout=1 with its result after edge t+STAGES-1 (STAGES cycles incl.
//   capture), with no downstream stall. Throughput: 1 per cycle while stopin=0.
//  Boundaries: full pipe + stopin=1 -> stopout=1, no state change; stopin drops -> all stages advance
//   same edge, new input accepted same edge. pushin=0 with stopin=0 -> bubble propagates, pushout=0.
//  Outputs z/cout/zf are registered; when pushout=0 their values are don't-care except after reset.
// CONFIGURATION
//  ALU_OVF_EN defined: extra output port ovf (1 bit), signed two's-complement overflow for ops 001/010,
//   0 for all other ops; pipelined with the result; reset 0.
//  ALU_OVF_EN undefined: no ovf port, no overflow logic.
// TESTING (W=8, STAGES=2 unless noted)
//  Add: ctl=001 a=FF b=01 ci=0, stopin=0 -> 2 cycles later pushout=1 z=00 cout=1 zf=1 (ovf=0).
//  Sub: ctl=010 a=05 b=07 ci=1 -> z=FE cout=0 zf=0; a=80 b=01 ci=1 -> z=7F cout=1 (ovf=1).
//  Shift: ctl=110 a=81 b=01 -> z=02 cout=1; ctl=111 a=81 b=00 -> z=81 cout=0; ctl=011 a=F0 b=FF -> 0F cout=0.
//  Stall: stopin=1, push 3 back-to-back -> stopout=1 from 3rd offer on; release stopin -> 3 results in order, none lost.
//  Reset mid-stream: 2 in flight, assert rst 1 cycle -> next cycle pushout=0 z=0 zf=1; no stale result ever emerges.
//  Sweep STAGES=1..4, W=4/13/64: random ops vs reference model, random stopin; compare order and values.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: parametrised multi-stage ALU with push/stop flow control.
// W-bit operands, 8 ops on a 3-bit ctl, zero flag, STAGES register stages.
// Optional macro ALU_OVF_EN adds a pipelined signed-overflow output port ovf.
module alu_pipe #(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pushin,
  output logic         stopout,
  input  logic [2:0]   ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         pushout,
  input  logic         stopin,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         zf
`ifdef ALU_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned SW = $clog2(W);
  // Stage payload is {zf, cout, z}
  localparam int unsigned DW = W + 2;
  localparam logic [DW-1:0] DATA_RST = {1'b1, 1'b0, {W{1'b0}}};

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  logic [SW-1:0] sh_amt;
  logic          sh_big;
  logic [W-1:0]  b_eff;
  logic [W:0]    sum;
  logic [W:0]    shl;
  logic [W:0]    shr;
  logic [W-1:0]  res_z;
  logic          res_cout;
  logic          res_zf;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];
  logic [STAGES-1:0] hold;

  // Shared adder handles add and subtract (subtract inverts b; ci=1 gives a-b)
  assign b_eff  = (ctl == OP_SUB) ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, ci};

  // Shifts carry one extra bit so the last bit shifted out lands in cout
  assign sh_amt = b[SW-1:0];
  assign sh_big = 32'(sh_amt) >= W;
  assign shl    = {1'b0, a} << sh_amt;
  assign shr    = {a, 1'b0} >> sh_amt;

  // Operation select at the input
  always_comb begin
    res_z    = '0;
    res_cout = 1'b0;
    unique case (ctl)
      OP_PASS: res_z = a;
      OP_ADD,
      OP_SUB:  {res_cout, res_z} = sum;
      OP_XOR:  res_z = a ^ b;
      OP_AND:  res_z = a & b;
      OP_OR:   res_z = a | b;
      OP_SHL:  if (!sh_big) {res_cout, res_z} = shl;
      OP_SHR:  if (!sh_big) {res_z, res_cout} = shr;
      default: res_z = '0;
    endcase
    res_zf = (res_z == '0);
  end

  // Stage k holds when it and every stage after it is full and the consumer stalls
  always_comb begin
    logic h;
    hold = '0;
    h    = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      h = stopin;
      for (int j = k; j < STAGES; j++) h = h & valid_q[j];
      hold[k] = h;
    end
  end

  assign stopout = hold[0];

  // Next state: non-holding stages load from their predecessor; bubbles collapse
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold[0]) begin
      valid_d[0] = pushin;
      if (pushin) data_d[0] = {res_zf, res_cout, res_z};
    end
    for (int k = 1; k < STAGES; k++) begin
      if (!hold[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= DATA_RST;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign pushout = valid_q[STAGES-1];
  assign z       = data_q[STAGES-1][W-1:0];
  assign cout    = data_q[STAGES-1][W];
  assign zf      = data_q[STAGES-1][W+1];

`ifdef ALU_OVF_EN
  logic              res_ovf;
  logic [STAGES-1:0] ovf_q, ovf_d;

  // Signed overflow: operands agree in sign but the result does not
  assign res_ovf = ((ctl == OP_ADD) || (ctl == OP_SUB)) &&
                   (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

  // Overflow bit follows the same load/hold pattern as the payload
  always_comb begin
    ovf_d = ovf_q;
    if (!hold[0] && pushin) ovf_d[0] = res_ovf;
    for (int k = 1; k < STAGES; k++) begin
      if (!hold[k] && valid_q[k-1]) ovf_d[k] = ovf_q[k-1];
    end
  end

  // Overflow pipeline registers
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q[STAGES-1];
`endif

endmodule
